// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Purpose  : Source end of a four-phase req/ack handshake that carries a
//            WIDTH-bit word from the sysclk domain to a foreign clock domain.
//            Accepts a word from local logic, holds it stable on data_out,
//            drives req_out from a flop, synchronizes the returning ack and
//            reports normal completion (done) or REQ-phase timeout
//            (timeout_err).
// Ports    : sysclk      - clock, all logic on rising edge
//            reset_n     - asynchronous active-low reset
//            tx_valid    - local request to send tx_data
//            tx_data     - word to send, sampled only on accept
//            tx_ready    - block is idle and accepts tx_valid
//            req_out     - handshake request to the remote domain (flop)
//            data_out    - registered word presented to the remote domain
//            ack_async   - acknowledge from the remote domain (asynchronous)
//            done        - one-cycle pulse on normal completion
//            timeout_err - one-cycle pulse when the REQ phase times out
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_async,
  output logic             done,
  output logic             timeout_err
);

  // A single-stage synchronizer gives no metastability protection.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("cdc_handshake_tx: SYNC_STAGES must be at least 2");
    end
  endgenerate

  // Counter is at least one bit wide so TIMEOUT=0 still elaborates cleanly.
  localparam int                CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  C_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_sync;
  logic                   r_req;
  logic                   w_req_nxt;
  logic [WIDTH-1:0]       r_data;
  logic [WIDTH-1:0]       w_data_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_timed_out;
  logic                   w_timed_out_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   r_timeout_err;
  logic                   w_timeout_err_nxt;
  logic                   w_to_hit;

  // --------------------------------------------------------------------------
  // ack synchronizer: shift ack_async in at bit 0, use the last stage only.
  // --------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];

  // Timeout fires on the edge where the counter has reached TIMEOUT-1, which
  // makes req_out fall exactly TIMEOUT cycles after accept.
  assign w_to_hit = (TIMEOUT > 0) && (r_cnt == C_CNT_LAST);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_req         <= 1'b0;
      r_data        <= '0;
      r_cnt         <= '0;
      r_timed_out   <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_data        <= w_data_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timed_out   <= w_timed_out_nxt;
      r_done        <= w_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_req_nxt         = r_req;
    w_data_nxt        = r_data;
    w_cnt_nxt         = r_cnt;
    w_timed_out_nxt   = r_timed_out;
    w_done_nxt        = 1'b0;
    w_timeout_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // tx_ready is implied by being in IDLE.
        if (tx_valid) begin
          w_state_nxt     = ST_REQ;
          w_req_nxt       = 1'b1;
          w_data_nxt      = tx_data;
          w_cnt_nxt       = '0;
          w_timed_out_nxt = 1'b0;
        end
      end

      ST_REQ: begin
        // ack is checked first so a coincident ack beats the timeout.
        if (w_ack_sync) begin
          w_state_nxt = ST_RELEASE;
          w_req_nxt   = 1'b0;
        end else if (w_to_hit) begin
          w_state_nxt       = ST_RELEASE;
          w_req_nxt         = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_timed_out_nxt   = 1'b1;
        end else if (r_cnt != C_CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        // Waiting for ack low here also absorbs a late ack after a timeout.
        if (!w_ack_sync) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = !r_timed_out;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign tx_ready    = (r_state == ST_IDLE);
  assign req_out     = r_req;
  assign data_out    = r_data;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Purpose  : Directed self-checking bench for cdc_handshake_tx (WIDTH=8,
//            SYNC_STAGES=2, TIMEOUT=10). The remote responder is played
//            directly by the stimulus sequence with hand-computed timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

  logic       sysclk;
  logic       reset_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_async;
  logic       done;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int req_hi   = 0;
  int done_cnt = 0;
  int terr_cnt = 0;
  int data_bad = 0;
  logic [7:0] exp_data = 8'h00;

  cdc_handshake_tx #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .TIMEOUT     (10)
  ) dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_async   (ack_async),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic clr_cnts();
    req_hi   = 0;
    done_cnt = 0;
    terr_cnt = 0;
    data_bad = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (req_out)              req_hi++;
      if (done)                 done_cnt++;
      if (timeout_err)          terr_cnt++;
      if (data_out !== exp_data) data_bad++;
    end
  endtask

  task automatic accept(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    exp_data = d;
    clr_cnts();
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    ack_async = 1'b1;

    // ---------------- reset values ----------------
    repeat (3) tick();
    chk("rst_ack_sync", dut.w_ack_sync, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_req", req_out, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_data", data_out, 8'h00);
    ack_async = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    #1;
    chk("rel_tx_ready", tx_ready, 1);
    chk("rel_req", req_out, 0);
    chk("rel_done", done, 0);
    chk("rel_terr", timeout_err, 0);
    tick();

    // ---------------- basic transfer 0xA5 ----------------
    accept(8'hA5);                   // E0
    req_hi = 1;
    chk("basic_req_rise", req_out, 1);
    chk("basic_data", data_out, 8'hA5);
    chk("basic_busy", tx_ready, 0);
    run(3);                          // E0+1..3
    ack_async = 1'b1;                // first seen at E0+4
    run(6);                          // E0+4..9, req falls after E0+6
    chk("basic_req_len", req_hi, 6);
    ack_async = 1'b0;                // first seen at E0+10
    run(2);                          // E0+10..11
    chk("basic_no_early_done", done_cnt, 0);
    chk("basic_still_busy", tx_ready, 0);
    run(1);                          // E0+12
    chk("basic_done", done, 1);
    chk("basic_ready_with_done", tx_ready, 1);
    run(2);
    chk("basic_done_count", done_cnt, 1);
    chk("basic_data_stable", data_bad, 0);
    chk("basic_no_terr", terr_cnt, 0);

    // ---------------- busy rejection ----------------
    accept(8'h11);                   // E0
    tx_valid  = 1'b1;
    tx_data   = 8'h22;
    ack_async = 1'b1;
    chk("busy_data0", data_out, 8'h11);
    run(3);                          // E0+1..3
    chk("busy_req_fall", req_out, 0);
    chk("busy_data_req", data_out, 8'h11);
    ack_async = 1'b0;
    run(2);                          // E0+4..5
    chk("busy_release", tx_ready, 0);
    run(1);                          // E0+6
    chk("busy_done", done, 1);
    chk("busy_data_done", data_out, 8'h11);
    chk("busy_no_second", done_cnt, 1);
    chk("busy_data_stable", data_bad, 0);
    tick();                          // E0+7: 0x22 accepted on the done cycle
    tx_valid = 1'b0;
    exp_data = 8'h22;
    chk("busy_accept22", data_out, 8'h22);
    chk("busy_req22", req_out, 1);
    chk("busy_done_gone", done, 0);
    clr_cnts();
    ack_async = 1'b1;
    run(3);
    chk("busy22_req_fall", req_out, 0);
    ack_async = 1'b0;
    run(3);
    chk("busy22_done", done, 1);
    chk("busy22_done_count", done_cnt, 1);

    // ---------------- timeout ----------------
    accept(8'h5A);                   // E0, ack stays 0
    run(9);                          // E0+1..9
    chk("to_req_held", req_hi, 9);
    chk("to_no_early_terr", terr_cnt, 0);
    run(1);                          // E0+10
    chk("to_req_fall", req_out, 0);
    chk("to_terr", timeout_err, 1);
    run(1);                          // E0+11
    chk("to_ready", tx_ready, 1);
    chk("to_terr_pulse", timeout_err, 0);
    run(3);
    chk("to_no_done", done_cnt, 0);
    chk("to_terr_count", terr_cnt, 1);

    // ---------------- late ack after timeout ----------------
    accept(8'h66);                   // E0
    run(8);                          // E0+1..8
    ack_async = 1'b1;                // ack_sync rises after E0+10
    run(2);                          // E0+9..10
    chk("late_terr", timeout_err, 1);
    chk("late_req_fall", req_out, 0);
    run(4);                          // E0+11..14
    chk("late_held_release", tx_ready, 0);
    ack_async = 1'b0;                // IDLE after E0+17
    run(2);
    chk("late_still_release", tx_ready, 0);
    run(1);
    chk("late_idle", tx_ready, 1);
    chk("late_no_done", done_cnt, 0);
    chk("late_terr_count", terr_cnt, 1);

    // ---------------- ack coincides with counter == 9 ----------------
    accept(8'h77);                   // E0
    run(7);                          // E0+1..7
    ack_async = 1'b1;                // ack_sync=1 after E0+9
    run(2);                          // E0+8..9
    chk("sim_req_held", req_out, 1);
    run(1);                          // E0+10
    chk("sim_req_fall", req_out, 0);
    chk("sim_no_terr", timeout_err, 0);
    ack_async = 1'b0;
    run(3);                          // IDLE after E0+13
    chk("sim_done", done, 1);
    chk("sim_done_count", done_cnt, 1);
    chk("sim_terr_count", terr_cnt, 0);

    // ---------------- reset mid-handshake ----------------
    accept(8'h55);
    run(2);
    chk("mid_req_before", req_out, 1);
    reset_n = 1'b0;
    #2;
    chk("mid_req_async", req_out, 0);
    chk("mid_data_async", data_out, 8'h00);
    chk("mid_ready_async", tx_ready, 1);
    tick();
    #2 reset_n = 1'b1;
    tick();
    accept(8'h3C);
    chk("post_req", req_out, 1);
    ack_async = 1'b1;
    run(3);
    chk("post_req_fall", req_out, 0);
    ack_async = 1'b0;
    run(3);
    chk("post_done", done, 1);
    chk("post_data", data_out, 8'h3C);
    chk("post_done_count", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
